// File: rtl/time_setter.sv
// time_setter: operator entry of a minutes:seconds preset for the dispenser timer.
// Debounces the mode/up/down buttons, generates press and auto-repeat events,
// and walks IDLE -> EDIT_MIN -> EDIT_SEG -> COMMIT while driving the timer load
// interface.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   btnMode    - raw mode button (asynchronous, active high)
//   btnUp      - raw increment button (asynchronous, active high)
//   btnDown    - raw decrement button (asynchronous, active high)
//   setTime    - high while editing and for the two commit cycles
//   setSeg     - seconds preset, 0..59
//   setMin     - minutes preset, 0..59
//   editField  - 00 idle, 01 minutes, 10 seconds, 11 commit
module time_setter #(
  parameter int unsigned SIZE         = 6,
  parameter int unsigned DEB_CYCLES   = 20,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10,
  parameter int unsigned EDIT_TIMEOUT = 500,
  parameter int unsigned DEFAULT_MIN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnMode,
  input  logic            btnUp,
  input  logic            btnDown,
  output logic            setTime,
  output logic [SIZE-1:0] setSeg,
  output logic [SIZE-1:0] setMin,
  output logic [1:0]      editField
);

  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned TO_W    = $clog2(EDIT_TIMEOUT + 1);
  localparam int unsigned MAX_VAL = 59;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EDIT_MIN = 2'b01,
    EDIT_SEG = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  // Button index: 0 mode, 1 up, 2 down.
  logic [2:0]       sync1, sync2, level, level_prev;
  logic [DEB_W-1:0] deb_cnt [3];
  logic [2:0]       press;

  // Repeat index: 0 up, 1 down.
  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_phase;
  logic [1:0]       rpt_fire;

  logic mode_ev, up_ev, down_ev, any_ev;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt, to_d;
  logic            commit_cnt, commit_d;
  logic [SIZE-1:0] min_d, seg_d;
  logic            set_time_d;
  logic [1:0]      edit_field_d;
  logic            adjust, timeout_hit;

  // Synchronizers and per-button debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      level      <= '0;
      level_prev <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1      <= {btnDown, btnUp, btnMode};
      sync2      <= sync1;
      level_prev <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            level[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = level & ~level_prev;

  // rpt_cnt counts cycles since the last up/down event while the level is held.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rpt_fire[j] = level[j+1] & level_prev[j+1] &
                    ((!rpt_phase[j] && (rpt_cnt[j] == RPT_W'(REPEAT_DELAY))) ||
                     ( rpt_phase[j] && (rpt_cnt[j] == RPT_W'(REPEAT_RATE))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_phase <= '0;
      for (int j = 0; j < 2; j++) rpt_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!level[j+1]) begin
          rpt_cnt[j]   <= '0;
          rpt_phase[j] <= 1'b0;
        end else if (press[j+1] || rpt_fire[j]) begin
          rpt_cnt[j] <= RPT_W'(1);
          if (rpt_fire[j]) rpt_phase[j] <= 1'b1;
        end else begin
          rpt_cnt[j] <= rpt_cnt[j] + RPT_W'(1);
        end
      end
    end
  end

  assign mode_ev = press[0];
  assign up_ev   = press[1] | rpt_fire[0];
  assign down_ev = press[2] | rpt_fire[1];
  assign any_ev  = mode_ev | up_ev | down_ev;

  // Next-state, preset datapath and registered output values.
  always_comb begin
    state_d      = state_q;
    min_d        = setMin;
    seg_d        = setSeg;
    to_d         = '0;
    commit_d     = 1'b0;
    adjust       = !mode_ev && (up_ev ^ down_ev);
    timeout_hit  = (to_cnt == TO_W'(EDIT_TIMEOUT - 1)) && !any_ev;

    case (state_q)
      IDLE: begin
        if (mode_ev) state_d = EDIT_MIN;
      end
      EDIT_MIN: begin
        if (mode_ev)          state_d = EDIT_SEG;
        else if (timeout_hit) state_d = COMMIT;
        if (adjust) begin
          if (up_ev) min_d = (setMin == SIZE'(MAX_VAL)) ? '0 : setMin + SIZE'(1);
          else       min_d = (setMin == '0) ? SIZE'(MAX_VAL) : setMin - SIZE'(1);
        end
        to_d = any_ev ? '0 : to_cnt + TO_W'(1);
      end
      EDIT_SEG: begin
        if (mode_ev || timeout_hit) state_d = COMMIT;
        if (adjust) begin
          if (up_ev) seg_d = (setSeg == SIZE'(MAX_VAL)) ? '0 : setSeg + SIZE'(1);
          else       seg_d = (setSeg == '0) ? SIZE'(MAX_VAL) : setSeg - SIZE'(1);
        end
        to_d = any_ev ? '0 : to_cnt + TO_W'(1);
      end
      COMMIT: begin
        commit_d = !commit_cnt;
        if (commit_cnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A 00:00 preset would dispense immediately; bump it to one second.
    if ((state_q != COMMIT) && (state_d == COMMIT) && (min_d == '0) && (seg_d == '0))
      seg_d = SIZE'(1);

    set_time_d   = (state_d != IDLE);
    edit_field_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      to_cnt     <= '0;
      commit_cnt <= 1'b0;
      setTime    <= 1'b0;
      editField  <= 2'b00;
      setMin     <= SIZE'(DEFAULT_MIN);
      setSeg     <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt     <= to_d;
      commit_cnt <= commit_d;
      setTime    <= set_time_d;
      editField  <= edit_field_d;
      setMin     <= min_d;
      setSeg     <= seg_d;
    end
  end

endmodule
